// File: rtl/clock_pkg.sv
// Shared constants for the clock display: set-mode codes, active-low segment patterns
// {g,f,e,d,c,b,a}, and the digit-to-field mapping helpers.
package clock_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] MODE_HOUR_SET = 3'b111;
    localparam logic [2:0] MODE_MIN_SET  = 3'b110;
    localparam logic [2:0] MODE_SEC_SET  = 3'b101;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        FieldSec  = 2'd0,
        FieldMin  = 2'd1,
        FieldHour = 2'd2,
        FieldNone = 2'd3
    } field_e;

    // Digits are paired per field: idx 0/1 sec, 2/3 min, 4/5 hour.
    function automatic field_e field_of_idx(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: return FieldSec;
            3'd2, 3'd3: return FieldMin;
            3'd4, 3'd5: return FieldHour;
            default:    return FieldNone;
        endcase
    endfunction

    function automatic field_e field_of_mode(input logic [2:0] mode);
        case (mode)
            MODE_HOUR_SET: return FieldHour;
            MODE_MIN_SET:  return FieldMin;
            MODE_SEC_SET:  return FieldSec;
            default:       return FieldNone;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes render a dash.
module seg7_decoder (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    import clock_pkg::*;

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_scanner.sv
// Scans HH.MM.SS onto a 6-digit common-anode display, one digit per DIGIT_DIV clocks,
// blinking the field being set and latching the time once per frame for coherence.
module time_display_scanner #(
    parameter int unsigned DIGIT_DIV = 50_000,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [2:0] mode,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    import clock_pkg::*;

    localparam int unsigned DCNT_W   = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam int unsigned BCNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [2:0]  LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [DCNT_W-1:0] r_dcnt;
    logic [2:0]        r_idx;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_phase;

    logic [4:0]        r_hour;
    logic [5:0]        r_min;
    logic [5:0]        r_sec;
    logic [2:0]        r_mode;

    logic [5:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;

    logic              w_tick;
    logic              w_bwrap;
    logic              w_frame_end;
    field_e            w_field;
    field_e            w_set_field;
    logic [5:0]        w_val;
    logic [5:0]        w_limit;
    logic              w_in_range;
    logic [3:0]        w_tens;
    logic [3:0]        w_ones;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg;
    logic              w_blank;
    logic              w_dp_on;

    assign w_tick      = (r_dcnt == DCNT_W'(DIGIT_DIV - 1));
    assign w_bwrap     = (r_bcnt == BCNT_W'(BLINK_DIV - 1));
    assign w_frame_end = w_tick && (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcnt <= '0;
            r_idx  <= 3'd0;
        end else if (w_tick) begin
            r_dcnt <= '0;
            r_idx  <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_dcnt <= r_dcnt + DCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_bwrap) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt  <= r_bcnt + BCNT_W'(1);
        end
    end

    // Latch on the last digit's final cycle so the next frame is drawn from one coherent time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hour <= '0;
            r_min  <= '0;
            r_sec  <= '0;
            r_mode <= '0;
        end else if (w_frame_end) begin
            r_hour <= hour;
            r_min  <= min;
            r_sec  <= sec;
            r_mode <= mode;
        end
    end

    always_comb begin
        w_field = field_of_idx(r_idx);
        w_val   = '0;
        w_limit = 6'd59;
        case (w_field)
            FieldSec:  w_val = r_sec;
            FieldMin:  w_val = r_min;
            FieldHour: begin
                w_val   = {1'b0, r_hour};
                w_limit = 6'd23;
            end
            default:   w_val = '0;
        endcase
    end

    assign w_in_range = (w_val <= w_limit);
    assign w_tens     = 4'(w_val / 6'd10);
    assign w_ones     = 4'(w_val % 6'd10);
    // Code 15 decodes to a dash, which marks an out-of-range field on both digits.
    assign w_digit    = !w_in_range ? 4'hF : (r_idx[0] ? w_tens : w_ones);

    assign w_set_field = field_of_mode(r_mode);
    assign w_blank     = r_phase && (w_set_field != FieldNone) && (w_set_field == w_field);
    assign w_dp_on     = (r_idx == 3'd2) || (r_idx == 3'd4);

    seg7_decoder u_seg7_decoder (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 6'b111111;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_blank ? 6'b111111 : ~(6'b000001 << r_idx);
            r_seg <= w_seg;
            r_dp  <= w_blank | ~w_dp_on;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
